// File: rtl/toy_fetch_queue_if.sv
// Fetch-queue bundle: instruction memory request/response, decode handshake,
// redirect and occupancy. The slave side is the fetch queue itself.
interface toy_fetch_queue_if #(
    parameter int AW    = 30,
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          ENABLE;
    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic [DW-1:0] INSTR;
    logic          DEC_VALID;
    logic [DW-1:0] DEC_INSTR;
    logic [AW-1:0] DEC_PC;
    logic          DEC_READY;
    logic          REDIR_VALID;
    logic [AW-1:0] REDIR_ADDR;
    logic [CW-1:0] COUNT;

    modport master (
        output ENABLE, INSTR, DEC_READY, REDIR_VALID, REDIR_ADDR,
        input  IREQ, IADDR, DEC_VALID, DEC_INSTR, DEC_PC, COUNT
    );

    modport slave (
        input  ENABLE, INSTR, DEC_READY, REDIR_VALID, REDIR_ADDR,
        output IREQ, IADDR, DEC_VALID, DEC_INSTR, DEC_PC, COUNT
    );
endinterface

// File: rtl/toy_fetch_queue.sv
// Instruction prefetch queue: sequential fetch PC, one-cycle memory response
// slot and a DEPTH-entry FIFO of {instruction, PC} feeding decode.
module toy_fetch_queue #(
    parameter int            AW     = 30,
    parameter int            DW     = 32,
    parameter int            DEPTH  = 4,
    parameter logic [AW-1:0] RST_PC = '0
) (
    input logic              CLK,
    input logic              RSTN,
    toy_fetch_queue_if.slave fq_if
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    logic [AW-1:0] r_pc;
    logic          r_infl;
    logic [AW-1:0] r_infl_pc;
    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_dec_valid;
    logic          w_pop;
    logic          w_push;
    logic [CW:0]   w_occ;
    logic          w_room;
    logic          w_ireq;

    // A redirect hides the head so nothing is consumed from a stale path.
    assign w_dec_valid = (r_count != '0) & ~fq_if.REDIR_VALID;
    assign w_pop       = w_dec_valid & fq_if.DEC_READY;
    assign w_push      = r_infl & ~fq_if.REDIR_VALID;

    // Reserve a slot for the response in flight so a new request can never overflow.
    assign w_occ  = {1'b0, r_count} + (CW+1)'(r_infl) - (CW+1)'(w_pop);
    assign w_room = w_occ < (CW+1)'(DEPTH);
    assign w_ireq = RSTN & fq_if.ENABLE & ~fq_if.REDIR_VALID & w_room;

    assign fq_if.IREQ      = w_ireq;
    assign fq_if.IADDR     = r_pc;
    assign fq_if.DEC_VALID = w_dec_valid;
    assign fq_if.DEC_INSTR = r_mem[r_rptr].instr;
    assign fq_if.DEC_PC    = r_mem[r_rptr].pc;
    assign fq_if.COUNT     = r_count;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_pc      <= RST_PC;
            r_infl    <= 1'b0;
            r_infl_pc <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else if (fq_if.REDIR_VALID) begin
            r_pc      <= fq_if.REDIR_ADDR;
            r_infl    <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_infl    <= w_ireq;
            r_infl_pc <= r_pc;
            if (w_ireq) r_pc   <= r_pc + AW'(1);
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; validity lives in the pointers and count.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr] <= '{instr: fq_if.INSTR, pc: r_infl_pc};
    end
endmodule

// File: tb/tb_toy_fetch_queue.sv
// Bench for toy_fetch_queue: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_toy_fetch_queue;
    localparam int            AW     = 30;
    localparam int            DW     = 32;
    localparam int            DEPTH  = 4;
    localparam logic [AW-1:0] RST_PC = '0;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    toy_fetch_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) fq_if ();

    toy_fetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RST_PC(RST_PC)) dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .fq_if (fq_if)
    );

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    // Memory: answers the cycle after a request, garbage otherwise.
    always @(posedge CLK)
        fq_if.INSTR <= fq_if.IREQ ? memf(fq_if.IADDR) : DW'($urandom());

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched {instr, pc}, one response slot, a PC.
    typedef struct {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } ent_t;
    ent_t          mq[$];
    logic          m_infl;
    logic [AW-1:0] m_infl_pc;
    logic [AW-1:0] m_pc;
    logic          c_redir;
    logic [AW-1:0] c_raddr;
    logic          e_ireq;
    logic          e_pop;

    task automatic model_reset();
        mq.delete();
        m_infl    = 1'b0;
        m_infl_pc = '0;
        m_pc      = RST_PC;
    endtask

    task automatic drive(input logic en, input logic rdy, input logic redir, input logic [AW-1:0] raddr);
        fq_if.ENABLE      = en;
        fq_if.DEC_READY   = rdy;
        fq_if.REDIR_VALID = redir;
        fq_if.REDIR_ADDR  = raddr;
        c_redir = redir;
        c_raddr = raddr;
    endtask

    // Drive a cycle's inputs, then check the DUT against the model mid-cycle.
    task automatic step_a(input logic en, input logic rdy, input logic redir, input logic [AW-1:0] raddr);
        int  occ;
        bit  dv;
        drive(en, rdy, redir, raddr);
        @(negedge CLK);
        dv     = (mq.size() != 0) && !redir;
        e_pop  = dv && rdy;
        occ    = mq.size() + (m_infl ? 1 : 0) - (e_pop ? 1 : 0);
        e_ireq = en && !redir && (occ < DEPTH);
        chk("ireq", 64'(fq_if.IREQ), 64'(e_ireq));
        if (e_ireq) chk("iaddr", 64'(fq_if.IADDR), 64'(m_pc));
        chk("dec_valid", 64'(fq_if.DEC_VALID), 64'(dv));
        if (dv) begin
            chk("dec_pc", 64'(fq_if.DEC_PC), 64'(mq[0].pc));
            chk("dec_instr", 64'(fq_if.DEC_INSTR), 64'(mq[0].instr));
        end
        chk("count", 64'(fq_if.COUNT), 64'(mq.size()));
    endtask

    task automatic step_b();
        @(posedge CLK);
        if (c_redir) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = c_raddr;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (m_infl) mq.push_back('{instr: memf(m_infl_pc), pc: m_infl_pc});
            m_infl    = e_ireq;
            m_infl_pc = m_pc;
            if (e_ireq) m_pc = m_pc + AW'(1);
        end
        #1;
    endtask

    typedef struct {
        int en, rdy, redir, raddr;
        int ireq, iaddr, dv, dpc, cnt;
    } vec_t;
    vec_t tbl[14];

    initial begin
        logic [AW-1:0] prev;
        logic [AW-1:0] wexp[4];
        int            n;

        // Streaming start, redirect to 0x100, then decode stall filling the queue.
        tbl[0]  = '{1, 1, 0, 0,     1, 0,     0, 0,     0};
        tbl[1]  = '{1, 1, 0, 0,     1, 1,     0, 0,     0};
        tbl[2]  = '{1, 1, 0, 0,     1, 2,     1, 0,     1};
        tbl[3]  = '{1, 1, 0, 0,     1, 3,     1, 1,     1};
        tbl[4]  = '{1, 1, 1, 'h100, 0, 0,     0, 0,     1};
        tbl[5]  = '{1, 1, 0, 0,     1, 'h100, 0, 0,     0};
        tbl[6]  = '{1, 1, 0, 0,     1, 'h101, 0, 0,     0};
        tbl[7]  = '{1, 1, 0, 0,     1, 'h102, 1, 'h100, 1};
        tbl[8]  = '{1, 0, 0, 0,     1, 'h103, 1, 'h101, 1};
        tbl[9]  = '{1, 0, 0, 0,     1, 'h104, 1, 'h101, 2};
        tbl[10] = '{1, 0, 0, 0,     0, 0,     1, 'h101, 3};
        tbl[11] = '{1, 0, 0, 0,     0, 0,     1, 'h101, 4};
        tbl[12] = '{1, 1, 0, 0,     1, 'h105, 1, 'h101, 4};
        tbl[13] = '{1, 1, 0, 0,     1, 'h106, 1, 'h102, 3};

        model_reset();
        drive(1'b1, 1'b1, 1'b0, '0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ireq", 64'(fq_if.IREQ), 64'(0));
        chk("rst_dec_valid", 64'(fq_if.DEC_VALID), 64'(0));
        chk("rst_count", 64'(fq_if.COUNT), 64'(0));
        RSTN = 1'b1;

        foreach (tbl[i]) begin
            step_a(1'(tbl[i].en), 1'(tbl[i].rdy), 1'(tbl[i].redir), AW'(tbl[i].raddr));
            chk($sformatf("tbl%0d_ireq", i), 64'(fq_if.IREQ), 64'(tbl[i].ireq));
            if (tbl[i].ireq != 0) chk($sformatf("tbl%0d_iaddr", i), 64'(fq_if.IADDR), 64'(tbl[i].iaddr));
            chk($sformatf("tbl%0d_dv", i), 64'(fq_if.DEC_VALID), 64'(tbl[i].dv));
            if (tbl[i].dv != 0) chk($sformatf("tbl%0d_dpc", i), 64'(fq_if.DEC_PC), 64'(tbl[i].dpc));
            chk($sformatf("tbl%0d_cnt", i), 64'(fq_if.COUNT), 64'(tbl[i].cnt));
            step_b();
        end

        // One ENABLE=0 cycle with a response outstanding.
        repeat (6) begin step_a(1'b1, 1'b1, 1'b0, '0); step_b(); end
        step_a(1'b1, 1'b1, 1'b0, '0);
        prev = fq_if.IADDR;
        step_b();
        step_a(1'b0, 1'b1, 1'b0, '0);
        chk("en0_ireq", 64'(fq_if.IREQ), 64'(0));
        step_b();
        step_a(1'b1, 1'b1, 1'b0, '0);
        chk("en0_resume_ireq", 64'(fq_if.IREQ), 64'(1));
        chk("en0_resume_iaddr", 64'(fq_if.IADDR), 64'(prev + AW'(1)));
        step_b();

        // PC wrap at the top of the address space.
        wexp[0] = '1 - AW'(1);
        wexp[1] = '1;
        wexp[2] = '0;
        wexp[3] = AW'(1);
        step_a(1'b1, 1'b1, 1'b1, wexp[0]);
        step_b();
        for (int k = 0; k < 4; k++) begin
            step_a(1'b1, 1'b1, 1'b0, '0);
            chk($sformatf("wrap%0d_iaddr", k), 64'(fq_if.IADDR), 64'(wexp[k]));
            step_b();
        end

        // Fill to three entries, then pulse reset mid-cycle.
        n = 0;
        while (mq.size() != 3 && n < 20) begin
            step_a(1'b1, 1'b0, 1'b0, '0);
            step_b();
            n++;
        end
        chk("fill3_reached", 64'(mq.size()), 64'(3));
        chk("fill3_count", 64'(fq_if.COUNT), 64'(3));
        RSTN = 1'b0;
        model_reset();
        #1;
        chk("arst_dec_valid", 64'(fq_if.DEC_VALID), 64'(0));
        chk("arst_count", 64'(fq_if.COUNT), 64'(0));
        chk("arst_ireq", 64'(fq_if.IREQ), 64'(0));
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        step_a(1'b1, 1'b1, 1'b0, '0);
        chk("post_rst_ireq", 64'(fq_if.IREQ), 64'(1));
        chk("post_rst_iaddr", 64'(fq_if.IADDR), 64'(RST_PC));
        step_b();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic          en, rdy, redir;
            logic [AW-1:0] ra;
            en    = ($urandom_range(0, 7) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 19) == 0);
            ra    = ($urandom_range(0, 3) == 0) ? ('1 - AW'($urandom_range(0, 3))) : AW'($urandom());
            step_a(en, rdy, redir, ra);
            step_b();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/toy_fetch_queue.md
TOY_FETCH_QUEUE -- requirements
Module: toy_fetch_queue

Interface
REQ-001 Parameter AW, 30, instruction word-address width.
REQ-002 Parameter DW, 32, instruction width.
REQ-003 Parameter DEPTH, 4, prefetch queue entries; power of two, minimum 2.
REQ-004 Parameter RST_PC, 0, word address fetched first after reset.
REQ-005 CLK  input  1  clock; all state updates on its rising edge.
REQ-006 RSTN  input  1  reset, asynchronous, active-low.
REQ-007 ENABLE  input  1  fetch permit; 0 suppresses new IREQ.
REQ-008 IREQ  output  1  instruction memory request.
REQ-009 IADDR  output  AW  word address of the request.
REQ-010 INSTR  input  DW  memory data; valid the cycle after an IREQ cycle.
REQ-011 DEC_VALID  output  1  queue head holds a valid instruction.
REQ-012 DEC_INSTR  output  DW  head instruction.
REQ-013 DEC_PC  output  AW  word address of the head instruction.
REQ-014 DEC_READY  input  1  decode accepts the head this cycle.
REQ-015 REDIR_VALID  input  1  branch/jump redirect request.
REQ-016 REDIR_ADDR  input  AW  redirect target word address.
REQ-017 COUNT  output  $clog2(DEPTH+1)  occupied queue entries.

Function
REQ-018 The block SHALL hold a fetch PC register, a DEPTH-entry FIFO of {instruction, PC} pairs, and a 1-bit in-flight flag with its PC.
REQ-019 pop SHALL be DEC_VALID & DEC_READY; the head entry leaves the FIFO on that edge.
REQ-020 IREQ SHALL be ENABLE & ~REDIR_VALID & (COUNT + inflight - pop < DEPTH), combinational.
REQ-021 IADDR SHALL equal the fetch PC register whenever IREQ = 1.
REQ-022 On an IREQ cycle the PC SHALL advance by 1 modulo 2^AW; 2^AW-1 wraps to 0.
REQ-023 The in-flight flag SHALL be set to IREQ on each edge, and its PC SHALL capture IADDR.
REQ-024 If the in-flight flag is 1 and REDIR_VALID = 0, {INSTR, in-flight PC} SHALL be pushed into the FIFO at the end of that cycle.
REQ-025 A push and a pop in the same cycle SHALL leave COUNT unchanged; the FIFO SHALL never overflow by construction of REQ-020.
REQ-026 Latency: IREQ in cycle t SHALL give DEC_VALID = 1 for that instruction no earlier than cycle t+2 (no bypass).
REQ-027 Sustained throughput with DEC_READY = 1 and ENABLE = 1 SHALL be one instruction per cycle for DEPTH >= 2.
REQ-028 When REDIR_VALID = 1, DEC_VALID SHALL be 0 and no pop SHALL occur.
REQ-029 When REDIR_VALID = 1, IREQ SHALL be 0.
REQ-030 At the end of a REDIR_VALID cycle, the block SHALL empty the FIFO, discard any in-flight response, and load PC with REDIR_ADDR.
REQ-031 After a redirect in cycle t with ENABLE = 1, IREQ SHALL assert in cycle t+1 with IADDR = REDIR_ADDR, and DEC_VALID SHALL assert in t+3.
REQ-032 Back-to-back REDIR_VALID cycles SHALL each restart as in REQ-030; the last target wins.
REQ-033 When ENABLE = 0, an in-flight response SHALL still be pushed, and the PC SHALL hold.
REQ-034 Instructions SHALL leave the FIFO in fetch order with DEC_PC consecutive modulo 2^AW between redirects.

Reset
REQ-035 While RSTN = 0, the block SHALL hold PC = RST_PC, the FIFO empty, the in-flight flag = 0, COUNT = 0, DEC_VALID = 0 and IREQ = 0.
REQ-036 Assertion of RSTN mid-operation SHALL discard all queued and in-flight instructions immediately.
REQ-037 In the first cycle after reset release with ENABLE = 1, IREQ SHALL be 1 with IADDR = RST_PC.

Verification
REQ-038 Reset release, ENABLE = 1, DEC_READY = 1, memory returns {8'hA5, addr} -> IREQ at t0 with IADDR 0, then 1, 2, ...; DEC_VALID from t0+2; DEC_PC 0, 1, 2 each cycle.
REQ-039 DEC_READY = 0, DEPTH = 4 -> COUNT reaches 4, IREQ drops; 4 requests plus none extra; DEC_READY = 1 -> drains in order with no loss or duplicate.
REQ-040 Streaming, REDIR_VALID = 1 with REDIR_ADDR = 0x100 at cycle t -> DEC_VALID = 0 at t, COUNT = 0 at t+1, IADDR = 0x100 at t+1, DEC_PC = 0x100 at t+3.
REQ-041 PC = 2^AW-2, streaming -> IADDR sequence 2^AW-2, 2^AW-1, 0, 1.
REQ-042 ENABLE = 0 for one cycle while a request is in flight -> that instruction is still enqueued; no IREQ that cycle; fetch resumes at the next address.
REQ-043 RSTN pulsed low with COUNT = 3 -> outputs return to reset values immediately; fetch restarts at RST_PC.
